// File: rtl/set_host_seq.sv
// Job sequencer for the SET circle-counting engine: fetches jobs from a sync-read pattern ROM,
// issues them over en/busy/valid, logs every candidate to a result RAM and scores the run.
module set_host_seq #(
    parameter int NUM_PAT   = 64,
    parameter int ADDR_W    = 6,
    parameter int TIMEOUT   = 1023,
    parameter int ERR_LIMIT = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode_sel,
    output logic [ADDR_W-1:0] pat_addr,
    input  logic [23:0]       pat_central,
    input  logic [11:0]       pat_radius,
    input  logic [7:0]        pat_expect,
    output logic              set_en,
    output logic [23:0]       set_central,
    output logic [11:0]       set_radius,
    output logic [1:0]        set_mode,
    input  logic              set_busy,
    input  logic              set_valid,
    input  logic [7:0]        set_candidate,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic [7:0]        res_data,
    output logic [6:0]        err_cnt,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_CHECK = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] pat_addr_q;
    logic [23:0]       job_central_q;
    logic [11:0]       job_radius_q;
    logic [7:0]        job_expect_q;
    logic              set_en_q;
    logic [23:0]       set_central_q;
    logic [11:0]       set_radius_q;
    logic [1:0]        set_mode_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              res_we_q;
    logic [ADDR_W-1:0] res_addr_q;
    logic [7:0]        res_data_q;
    logic [6:0]        err_cnt_q;
    logic [6:0]        err_cnt_d;
    logic              done_q;
    logic              pass_q;
    logic              timeout_q;

    // Score of the job sitting in CHECK: res_data_q holds the captured candidate.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((res_data_q != job_expect_q) && (err_cnt_q != 7'd127)) begin
            err_cnt_d = err_cnt_q + 7'd1;
        end
    end

    // Handshake: set_en is a one-cycle job strobe, issued only after a cycle with set_busy=0;
    // operands stay put until the next strobe. A result is taken on any cycle with set_valid=1
    // while in WAIT, except the strobe cycle itself; set_valid anywhere else is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            pat_addr_q    <= '0;
            job_central_q <= '0;
            job_radius_q  <= '0;
            job_expect_q  <= '0;
            set_en_q      <= 1'b0;
            set_central_q <= '0;
            set_radius_q  <= '0;
            set_mode_q    <= '0;
            wait_cnt_q    <= '0;
            res_we_q      <= 1'b0;
            res_addr_q    <= '0;
            res_data_q    <= '0;
            err_cnt_q     <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            set_en_q <= 1'b0;
            res_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err_cnt_q  <= '0;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        timeout_q  <= 1'b0;
                        idx_q      <= '0;
                        pat_addr_q <= '0;
                        set_mode_q <= mode_sel;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    job_central_q <= pat_central;
                    job_radius_q  <= pat_radius;
                    job_expect_q  <= pat_expect;
                    state_q       <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!set_busy) begin
                        set_en_q      <= 1'b1;
                        set_central_q <= job_central_q;
                        set_radius_q  <= job_radius_q;
                        wait_cnt_q    <= '0;
                        state_q       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (set_valid && !set_en_q) begin
                        res_we_q   <= 1'b1;
                        res_addr_q <= idx_q;
                        res_data_q <= set_candidate;
                        state_q    <= S_CHECK;
                    end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        pass_q    <= 1'b0;
                        state_q   <= S_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                S_CHECK: begin
                    err_cnt_q <= err_cnt_d;
                    if ((err_cnt_d == 7'(ERR_LIMIT)) || (idx_q == ADDR_W'(NUM_PAT - 1))) begin
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == 7'd0);
                        state_q <= S_DONE;
                    end else begin
                        idx_q      <= idx_q + 1'b1;
                        pat_addr_q <= idx_q + 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pat_addr    = pat_addr_q;
    assign set_en      = set_en_q;
    assign set_central = set_central_q;
    assign set_radius  = set_radius_q;
    assign set_mode    = set_mode_q;
    assign res_we      = res_we_q;
    assign res_addr    = res_addr_q;
    assign res_data    = res_data_q;
    assign err_cnt     = err_cnt_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign dbg_state   = state_q;

endmodule
